modsub_arbiter: RTL and testbench
=================================

# modsub_arbiter

Round-robin arbiter that shares one 2-stage modular-subtraction pipeline among `N_REQ` requesters (NTT butterfly lanes, twiddle-prep, INTT post-processing) inside the NTT core. It accepts at most one operand pair per cycle over valid/ready, tracks the issuing requester through the pipeline with a tag shift register, and routes each result back as a one-cycle response pulse. It also provides drain control (`en`, `busy`) and an issue counter for the NTT sequencer.

## Interface
- `K`, `` `K ``: operand and modulus width.
- `N_REQ`, 4: number of requesters, ≥2.
- `CNT_W`, 16: width of `issued_cnt`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: grant enable. When low, no new issues; in-flight ops complete.
- `mod` input K: modulus. Held stable while `busy`=1.
- `req_valid` input N_REQ: per-requester request.
- `req_a` input N_REQ×K: minuend, requester i in slice i. Must be < `mod`.
- `req_b` input N_REQ×K: subtrahend, must be < `mod`.
- `req_ready` output N_REQ: one-hot or zero grant.
- `rsp_valid` output N_REQ: one-hot or zero, one-cycle result pulse.
- `rsp_data` output K: (a−b) mod `mod`; valid only when some `rsp_valid` bit is set.
- `busy` output 1: any op in flight.
- `issued_cnt` output CNT_W: total accepted ops, wraps modulo 2^CNT_W.

## Operation
- Grant: `req_ready[i]` = `en` & `req_valid[i]` & i is the first valid index strictly after `last_grant`, searching cyclically. This path is combinational from `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Issue: a handshake (`req_valid[i]` & `req_ready[i]` at an edge) muxes `req_a[i]`/`req_b[i]` into the pipeline. On the same edge, `last_grant` ← i, stage-0 tag ← {1, i}, and `issued_cnt` += 1.
- With no handshake, stage-0 tag valid ← 0. Operands fed to the pipeline are don't-care.
- Tag pipeline: stage-1 tag ← stage-0 tag each edge. `rsp_valid[j]` = stage-1 valid & (stage-1 id == j). `rsp_data` = pipeline result.
- No response backpressure. Each requester must accept its pulse in that cycle.
- `busy` = stage-0 valid | stage-1 valid.
- Arithmetic: the subtractor forms a K+1-bit difference a−b. If bit K is set, it adds `mod`, truncated to K bits. Inputs ≥ `mod` give undefined results; no check is made.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ−1,0. No requester waits more than N_REQ−1 cycles while valid and `en`=1.
- Reset values: `last_grant`=N_REQ−1 (so index 0 wins first), tag valids 0, `issued_cnt` 0, `rsp_valid` 0, `busy` 0, `req_ready` 0.
- Reset mid-operation: all tag valids clear and in-flight results are dropped. No `rsp_valid` appears after deassertion for ops issued before reset. Pipeline data registers are not reset.
- `en` falling: no further grants from that cycle on. `busy` falls 2 cycles after the last issue.
- `issued_cnt` wraps from 2^CNT_W−1 to 0 silently.

## Timing
- Latency 2: a handshake at edge E0 produces `rsp_valid`/`rsp_data` during the cycle after edge E1 (E0+1).
- Throughput: 1 op/cycle aggregate.
- A requester may issue back-to-back only when it is the sole valid requester.
- `req_ready` has zero-cycle response to `req_valid` and `en`.
- `issued_cnt` updates on the handshake edge.

## Structure
- Shared package `ntt_pkg`: `MODSUB_LAT`=2, `ID_W`=$clog2(N_REQ), and a tag struct {valid, id}.
- Sub-module: the existing `mod_subtraction` is instantiated once as the datapath. This block adds the round-robin grant logic, the 2-deep tag pipeline, and the counter.
- Stage count of the tag pipeline is tied to `MODSUB_LAT` with an elaboration check.

## Test plan
- Single op: `mod`=17, requester 2 sends a=3, b=5 → `req_ready[2]` same cycle; `rsp_valid`=4'b0100 and `rsp_data`=15 two cycles later; `issued_cnt`=1.
- No-wrap and zero cases: a=10, b=4 → 6; a=9, b=9 → 0; a=0, b=16 → 1 (`mod`=17). Each result arrives at latency 2.
- Fairness: all 4 requesters held valid for 8 cycles after reset → grant order 0,1,2,3,0,1,2,3; responses in the same order, each 2 cycles after its grant.
- Drain: drop `en` the cycle after issuing 2 back-to-back ops → no further `req_ready`; both responses arrive; `busy` returns to 0 exactly 2 cycles after the last issue.
- Reset mid-flight: issue an op, assert `rst_n`=0 for one cycle the next cycle → no `rsp_valid` afterwards; `issued_cnt`=0; first post-reset grant goes to requester 0.
- Counter wrap: `CNT_W`=4, issue 17 ops → `issued_cnt` = 1.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared NTT-core definitions: modular-subtraction pipeline depth and the
// requester tag that travels alongside operands through that pipeline.
`ifndef K
`define K 32
`endif

package ntt_pkg;

  localparam int MODSUB_LAT = 2;
  localparam int NTT_N_REQ  = 4;
  localparam int ID_W       = $clog2(NTT_N_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } modsub_tag_t;

  function automatic modsub_tag_t tag_make(input logic valid, input logic [ID_W-1:0] id);
    modsub_tag_t t;
    t.valid = valid;
    t.id    = id;
    return t;
  endfunction

endpackage

// File: rtl/mod_subtraction.sv
// Two-stage modular subtractor: res = (a - b) mod mod for a, b < mod.
// Data registers carry no reset; validity is tracked by the caller.
module mod_subtraction #(
  parameter int K = `K
) (
  input  logic         clk,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic [K-1:0] mod,
  output logic [K-1:0] res
);

  logic [K:0]   diff_r;
  logic [K-1:0] res_r;

  // Stage 1: raw K+1-bit difference, bit K set when a < b.
  always_ff @(posedge clk) begin
    diff_r <= {1'b0, a} - {1'b0, b};
  end

  // Stage 2: fold a borrowed difference back into [0, mod).
  always_ff @(posedge clk) begin
    if (diff_r[K]) begin
      res_r <= diff_r[K-1:0] + mod;
    end else begin
      res_r <= diff_r[K-1:0];
    end
  end

  assign res = res_r;

endmodule

// File: rtl/modsub_arbiter.sv
// Round-robin front end sharing one mod_subtraction pipeline among N_REQ
// requesters; a tag shift register routes each result back to its issuer.
module modsub_arbiter
  import ntt_pkg::*;
#(
  parameter int K     = `K,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [K-1:0]       mod,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*K-1:0] req_a,
  input  logic [N_REQ*K-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [K-1:0]       rsp_data,
  output logic               busy,
  output logic [CNT_W-1:0]   issued_cnt
);

  // The datapath below has exactly two register stages; the tag pipe must match.
  if (MODSUB_LAT != 2) begin : g_lat_chk
    $error("modsub_arbiter: MODSUB_LAT must equal the mod_subtraction depth (2)");
  end
  if (N_REQ < 2 || $clog2(N_REQ) > ID_W) begin : g_nreq_chk
    $error("modsub_arbiter: N_REQ must be >= 2 and fit the shared tag id width");
  end

  logic [ID_W-1:0]  last_grant_r;
  logic [ID_W-1:0]  grant_id_s;
  logic             grant_hit_s;
  logic             issue_s;
  logic [N_REQ-1:0] ready_s;
  logic [K-1:0]     op_a_s;
  logic [K-1:0]     op_b_s;
  logic [K-1:0]     res_s;
  logic [CNT_W-1:0] cnt_r;
  logic [N_REQ-1:0] rsp_valid_s;
  logic             busy_s;
  modsub_tag_t      tag_r [MODSUB_LAT];

  // Cyclic search for the first valid requester strictly after last_grant.
  always_comb begin : grant_search
    int idx;
    grant_hit_s = 1'b0;
    grant_id_s  = {ID_W{1'b0}};
    idx         = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = int'(last_grant_r) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!grant_hit_s && req_valid[idx]) begin
        grant_hit_s = 1'b1;
        grant_id_s  = ID_W'(idx);
      end else begin
        grant_hit_s = grant_hit_s;
      end
    end
  end

  // One-hot grant; a grant always coincides with a handshake since it needs req_valid.
  always_comb begin
    ready_s = {N_REQ{1'b0}};
    if (en && grant_hit_s) begin
      ready_s[grant_id_s] = 1'b1;
    end else begin
      ready_s = {N_REQ{1'b0}};
    end
  end

  assign issue_s   = en & grant_hit_s;
  assign req_ready = ready_s;
  assign op_a_s    = req_a[grant_id_s*K +: K];
  assign op_b_s    = req_b[grant_id_s*K +: K];

  mod_subtraction #(
    .K (K)
  ) u_sub (
    .clk (clk),
    .a   (op_a_s),
    .b   (op_b_s),
    .mod (mod),
    .res (res_s)
  );

  // Round-robin pointer and issue counter advance on every handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= ID_W'(N_REQ - 1);
      cnt_r        <= {CNT_W{1'b0}};
    end else if (issue_s) begin
      last_grant_r <= grant_id_s;
      cnt_r        <= cnt_r + CNT_W'(1);
    end else begin
      last_grant_r <= last_grant_r;
      cnt_r        <= cnt_r;
    end
  end

  // Tag shift register tracking which requester owns each pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MODSUB_LAT; s++) begin
        tag_r[s] <= tag_make(1'b0, {ID_W{1'b0}});
      end
    end else begin
      tag_r[0] <= tag_make(issue_s, grant_id_s);
      for (int s = 1; s < MODSUB_LAT; s++) begin
        tag_r[s] <= tag_r[s-1];
      end
    end
  end

  // Decode the final-stage tag into a one-hot response pulse.
  always_comb begin
    rsp_valid_s = {N_REQ{1'b0}};
    if (tag_r[MODSUB_LAT-1].valid) begin
      rsp_valid_s[tag_r[MODSUB_LAT-1].id] = 1'b1;
    end else begin
      rsp_valid_s = {N_REQ{1'b0}};
    end
  end

  // Busy while any stage holds a live op.
  always_comb begin
    busy_s = 1'b0;
    for (int s = 0; s < MODSUB_LAT; s++) begin
      busy_s = busy_s | tag_r[s].valid;
    end
  end

  assign rsp_valid  = rsp_valid_s;
  assign rsp_data   = res_s;
  assign busy       = busy_s;
  assign issued_cnt = cnt_r;

endmodule

// File: tb/tb_modsub_arbiter.sv
// Directed bench for modsub_arbiter: a reference round-robin model predicts
// grants, and a scoreboard queue holds expected responses with due cycles.
module tb_modsub_arbiter;

  localparam int K  = 8;
  localparam int N  = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [K-1:0]   mod;
  logic [N-1:0]   req_valid;
  logic [N*K-1:0] req_a;
  logic [N*K-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [K-1:0]   rsp_data;
  logic           busy;
  logic [CW-1:0]  issued_cnt;

  typedef struct {
    logic [1:0]   id;
    logic [K-1:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   m_last;
  int   m_cnt;
  logic hist0;
  logic hist1;

  modsub_arbiter #(.K(K), .N_REQ(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mod        (mod),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_sub(input int a, input int b, input int m);
    int d;
    d = a - b;
    if (d < 0) d = d + m;
    return d;
  endfunction

  task automatic set_req(input int id, input int a, input int b);
    req_valid[id]    = 1'b1;
    req_a[id*K +: K] = K'(a);
    req_b[id*K +: K] = K'(b);
  endtask

  task automatic clr_req();
    req_valid = '0;
  endtask

  // One clock: check response and grant before the edge, counter/busy after it.
  task automatic step();
    exp_t       e;
    logic [N-1:0] exp_rdy;
    int         g;
    int         idx;
    logic       hs;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'd0);
    end
    exp_rdy = '0;
    g = -1;
    if (en) begin
      for (int off = 1; off <= N; off++) begin
        idx = (m_last + off) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    hs = (g >= 0) && rst_n;
    @(posedge clk);
    #1;
    if (hs) begin
      e.id   = 2'(g);
      e.data = K'(model_sub(int'(req_a[g*K +: K]), int'(req_b[g*K +: K]), int'(mod)));
      e.due  = cyc + 1;
      sb.push_back(e);
      m_last = g;
      m_cnt  = (m_cnt + 1) % (1 << CW);
    end
    hist1 = hist0;
    hist0 = hs;
    chk("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(hist0 | hist1));
  endtask

  // Called just after an edge: one cycle of reset, then release.
  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    m_last = N - 1;
    m_cnt  = 0;
    hist0  = 1'b0;
    hist1  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_cnt", 32'(issued_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    mod       = 8'd17;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    m_last    = N - 1;
    m_cnt     = 0;
    hist0     = 1'b0;
    hist1     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(issued_cnt), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Single op: requester 2, 3 - 5 mod 17 = 15.
    set_req(2, 3, 5);
    step();
    clr_req();
    repeat (3) step();

    // No-wrap, zero and wrap-to-one results.
    set_req(0, 10, 4);
    step();
    clr_req();
    set_req(1, 9, 9);
    step();
    clr_req();
    set_req(3, 0, 16);
    step();
    clr_req();
    repeat (3) step();

    // Fairness: all requesters valid for eight cycles after reset.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 16 - i, i * 5);
    repeat (8) step();
    clr_req();
    repeat (3) step();

    // Drain: two back-to-back issues, then en drops while still requesting.
    set_req(1, 2, 7);
    step();
    step();
    en = 1'b0;
    repeat (4) step();
    clr_req();
    en = 1'b1;

    // Reset with an op in flight; its response must never appear.
    set_req(2, 5, 1);
    step();
    clr_req();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, i, 0);
    step();
    clr_req();
    repeat (3) step();

    // Counter wrap with a different modulus and random operands.
    do_reset();
    mod = 8'd251;
    for (int i = 0; i < 17; i++) begin
      set_req(3, int'($urandom_range(250, 0)), int'($urandom_range(250, 0)));
      step();
    end
    clr_req();
    chk("cnt_wrap", 32'(issued_cnt), 32'd1);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
